mul8_seq_ctrl: RTL
==================

# mul8_seq_ctrl

Sequencing controller that computes an 8x8 approximate product by time-multiplexing one shared 4x4 multiplier core over four partial-product phases (HH, HL, LH, LL). For each phase it drives the core's operand nibbles and selects the core's approximation variant. It accumulates the returned 8-bit partial products with the correct shifts into a 16-bit result and presents it on a valid/ready output. It sits between a streaming operand source and a single instance of the 4x4 approximate multiplier family, and replaces four parallel sub-multipliers plus the adder stage when area matters more than throughput.

## Interface
- SEL_HH, default 2'd0: variant code driven on mul_sel during the HH phase (ah x bh)
- SEL_HL, default 2'd0: variant code for the HL phase (ah x bl)
- SEL_LH, default 2'd1: variant code for the LH phase (al x bh)
- SEL_LL, default 2'd2: variant code for the LL phase (al x bl)
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  operand pair valid
- in_ready  out  1  controller can accept operands
- in_a  in  8  multiplicand; ah = in_a[7:4], al = in_a[3:0]
- in_b  in  8  multiplier; bh = in_b[7:4], bl = in_b[3:0]
- out_valid  out  1  out_prod valid
- out_ready  in  1  consumer accepts out_prod
- out_prod  out  16  accumulated product
- mul_a  out  4  operand nibble to shared core
- mul_b  out  4  operand nibble to shared core
- mul_sel  out  2  approximation variant select to shared core
- mul_act  out  1  high during a valid phase
- mul_prod  in  8  core product; combinational response to mul_a/mul_b/mul_sel in the same cycle
- busy  out  1  state != IDLE

## Operation
- States: IDLE, HH, HL, LH, LL, DONE.
- Accept: the operand pair is taken when in_valid && in_ready. in_a and in_b are registered at accept. The accumulator is cleared to 0 and the FSM moves to HH.
- in_ready = (state == IDLE) || (state == DONE && out_ready).
- Phase outputs (all from registered state and operands):
  - HH: mul_a = ah, mul_b = bh, mul_sel = SEL_HH.
  - HL: mul_a = ah, mul_b = bl, mul_sel = SEL_HL.
  - LH: mul_a = al, mul_b = bh, mul_sel = SEL_LH.
  - LL: mul_a = al, mul_b = bl, mul_sel = SEL_LL.
  - mul_act = 1 in all four phases.
- Outside the phases: mul_a = 0, mul_b = 0, mul_sel = 0, mul_act = 0.
- Accumulation at the end of each phase cycle: acc += zero-extended mul_prod shifted left by 8 (HH), 4 (HL, LH) or 0 (LL).
  - The sum is 16 bits and wraps modulo 2^16; there is no saturation.
- Transitions: HH -> HL -> LH -> LL -> DONE, one cycle each.
- On entering DONE, out_prod is loaded with the final accumulator value and out_valid = 1.
- DONE with out_ready = 1:
  - If in_valid = 1 as well, the new pair is accepted in the same cycle and the FSM goes directly to HH.
  - Otherwise the FSM returns to IDLE.
- DONE with out_ready = 0: the FSM holds; out_prod stays stable and in_ready = 0.
- out_prod holds its last value after the output handshake until the next DONE.
- Reset values: state IDLE; in_ready 1; out_valid 0; out_prod 0; accumulator 0; mul_a, mul_b, mul_sel, mul_act 0; busy 0.
- Reset asserted mid-operation aborts the operation immediately and asynchronously. No partial result is ever presented.

## Timing
- Accept in cycle 0. Phases occupy cycles 1-4. out_valid rises in cycle 5, giving a latency of 5.
- Sustained throughput with out_ready held high: one result per 5 cycles, back-to-back via the DONE-accept path.
- mul_prod is sampled at the rising edge that ends each phase cycle. The core path mul_a/mul_b to mul_prod to accumulator is a single-cycle combinational path.

## Configuration
- MUL8_SEQ_LL_SKIP_EN defined:
  - The LL phase is omitted; the sequence is LH -> DONE and the LL contribution is 0.
  - Latency is 4 and throughput is one result per 4 cycles.
  - SEL_LL is unused.
- Macro undefined: the full four-phase sequence as described above.

## Test plan
- Order and selects: exact stub core, a = 0x3C, b = 0xA5 -> exactly these (mul_a, mul_b, mul_sel) tuples on cycles 1-4: (3, A, 0), (3, 5, 0), (C, A, 1), (C, 5, 2); out_prod = 0x26AC with out_valid in cycle 5.
- Max operands: exact stub, a = b = 0xFF -> out_prod = 0xFE01. Overflow: stub that always returns 0xFF -> out_prod = 0x1FDF (wrapped).
- Backpressure: out_ready held low for 3 cycles after out_valid -> out_prod stable, in_ready = 0, a pending in_valid is not accepted. Releasing out_ready with in_valid high -> the new pair is accepted in that cycle and mul_act is high on the next cycle.
- Back-to-back: 4 random pairs with in_valid and out_ready held high -> results in order, spaced 5 cycles apart, each matching the reference model.
- Reset mid-LH: rst_n pulsed low during the LH phase -> outputs return to reset values immediately. After release, a = 0x12, b = 0x34 -> out_prod = 0x03A8 with no stale accumulation.
- LL skip (MUL8_SEQ_LL_SKIP_EN): exact stub, a = b = 0x0F -> out_prod = 0x0000 at latency 4; without the macro, out_prod = 0x00E1 at latency 5.

Source files
------------

// File: rtl/mul8_seq_ctrl_if.sv
// rtl/mul8_seq_ctrl_if.sv - operand stream, result stream and shared 4x4 core bus for mul8_seq_ctrl
interface mul8_seq_ctrl_if;
  // operand stream
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_a;
  logic [7:0]  in_b;
  // result stream
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_prod;
  // shared 4x4 core
  logic [3:0]  mul_a;
  logic [3:0]  mul_b;
  logic [1:0]  mul_sel;
  logic        mul_act;
  logic [7:0]  mul_prod;
  // status
  logic        busy;

  // controller side
  modport master (
    input  in_valid, in_a, in_b, out_ready, mul_prod,
    output in_ready, out_valid, out_prod, mul_a, mul_b, mul_sel, mul_act, busy
  );

  // environment side: operand source, result sink and the 4x4 core
  modport slave (
    output in_valid, in_a, in_b, out_ready, mul_prod,
    input  in_ready, out_valid, out_prod, mul_a, mul_b, mul_sel, mul_act, busy
  );
endinterface

// File: rtl/mul8_seq_ctrl.sv
// rtl/mul8_seq_ctrl.sv - 8x8 product via one shared 4x4 core over HH/HL/LH/LL phases; MUL8_SEQ_LL_SKIP_EN drops the LL phase
module mul8_seq_ctrl #(
  parameter logic [1:0] SEL_HH = 2'd0,
  parameter logic [1:0] SEL_HL = 2'd0,
  parameter logic [1:0] SEL_LH = 2'd1,
  parameter logic [1:0] SEL_LL = 2'd2
) (
  input  logic           clk,
  input  logic           rst_n,
  mul8_seq_ctrl_if.master bus
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    HH   = 3'd1,
    HL   = 3'd2,
    LH   = 3'd3,
    LL   = 3'd4,
    DONE = 3'd5
  } state_t;

  state_t      state_q,     state_d;
  logic [7:0]  a_q,         a_d;
  logic [7:0]  b_q,         b_d;
  logic [15:0] acc_q,       acc_d;
  logic [15:0] out_prod_q,  out_prod_d;
  logic        out_valid_q, out_valid_d;
  logic [3:0]  mul_a_q,     mul_a_d;
  logic [3:0]  mul_b_q,     mul_b_d;
  logic [1:0]  mul_sel_q,   mul_sel_d;
  logic        mul_act_q,   mul_act_d;
  logic        busy_q,      busy_d;

  logic        in_ready;
  logic        accept;
  logic [15:0] contrib;
  logic [15:0] acc_sum;

  // Input side is ready when idle, or when the finished result is being taken this cycle.
  assign in_ready = (state_q == IDLE) || ((state_q == DONE) && bus.out_ready);
  assign accept   = bus.in_valid && in_ready;

  // Shift the core's partial product into place for the phase that is ending this cycle.
  always_comb begin
    contrib = 16'h0000;
    case (state_q)
      HH:      contrib = {bus.mul_prod, 8'h00};
      HL, LH:  contrib = {4'h0, bus.mul_prod, 4'h0};
      LL:      contrib = {8'h00, bus.mul_prod};
      default: contrib = 16'h0000;
    endcase
    acc_sum = acc_q + contrib;
  end

  // Next-state, accumulator, result and phase-output computation.
  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    acc_d       = acc_q;
    out_prod_d  = out_prod_q;

    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = HH;
          a_d     = bus.in_a;
          b_d     = bus.in_b;
          acc_d   = 16'h0000;
        end
      end
      HH: begin
        state_d = HL;
        acc_d   = acc_sum;
      end
      HL: begin
        state_d = LH;
        acc_d   = acc_sum;
      end
      LH: begin
        acc_d = acc_sum;
`ifdef MUL8_SEQ_LL_SKIP_EN
        state_d    = DONE;
        out_prod_d = acc_sum;
`else
        state_d    = LL;
`endif
      end
      LL: begin
        state_d    = DONE;
        acc_d      = acc_sum;
        out_prod_d = acc_sum;
      end
      DONE: begin
        if (bus.out_ready) begin
          if (accept) begin
            state_d = HH;
            a_d     = bus.in_a;
            b_d     = bus.in_b;
            acc_d   = 16'h0000;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Core-facing outputs are registered, so they follow the state being entered.
    mul_a_d   = 4'h0;
    mul_b_d   = 4'h0;
    mul_sel_d = 2'd0;
    mul_act_d = 1'b0;
    case (state_d)
      HH: begin
        mul_a_d = a_d[7:4]; mul_b_d = b_d[7:4]; mul_sel_d = SEL_HH; mul_act_d = 1'b1;
      end
      HL: begin
        mul_a_d = a_d[7:4]; mul_b_d = b_d[3:0]; mul_sel_d = SEL_HL; mul_act_d = 1'b1;
      end
      LH: begin
        mul_a_d = a_d[3:0]; mul_b_d = b_d[7:4]; mul_sel_d = SEL_LH; mul_act_d = 1'b1;
      end
      LL: begin
        mul_a_d = a_d[3:0]; mul_b_d = b_d[3:0]; mul_sel_d = SEL_LL; mul_act_d = 1'b1;
      end
      default: begin
        mul_a_d   = 4'h0;
        mul_b_d   = 4'h0;
        mul_sel_d = 2'd0;
        mul_act_d = 1'b0;
      end
    endcase

    out_valid_d = (state_d == DONE);
    busy_d      = (state_d != IDLE);
  end

  // Single state register; reset aborts any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      a_q         <= 8'h00;
      b_q         <= 8'h00;
      acc_q       <= 16'h0000;
      out_prod_q  <= 16'h0000;
      out_valid_q <= 1'b0;
      mul_a_q     <= 4'h0;
      mul_b_q     <= 4'h0;
      mul_sel_q   <= 2'd0;
      mul_act_q   <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      acc_q       <= acc_d;
      out_prod_q  <= out_prod_d;
      out_valid_q <= out_valid_d;
      mul_a_q     <= mul_a_d;
      mul_b_q     <= mul_b_d;
      mul_sel_q   <= mul_sel_d;
      mul_act_q   <= mul_act_d;
      busy_q      <= busy_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.out_prod  = out_prod_q;
  assign bus.mul_a     = mul_a_q;
  assign bus.mul_b     = mul_b_q;
  assign bus.mul_sel   = mul_sel_q;
  assign bus.mul_act   = mul_act_q;
  assign bus.busy      = busy_q;

endmodule
